serial_packet_rx: RTL
=====================

Name: serial_packet_rx

Overview:
Receive end of the framed UART packet link between the game FPGAs and the host. Recovers 8N1 bytes from line_in and hunts for a sync byte. It collects NUM_BYTES payload bytes, checks an XOR checksum byte, and presents the payload as one word with a one-cycle valid pulse. Sits between the board RX pin and the game-state logic, and reports framing, checksum and timeout errors.

Parameters:
DIVISOR, 868, clk cycles per bit (100 MHz / 115200 baud).
NUM_BYTES, 4, payload bytes per packet (1..8).
SYNC_BYTE, 8'hA5, packet start marker.
TIMEOUT_BITS, 20, max idle gap between bytes inside a packet, in bit periods.

Ports:
clk  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
line_in  input  1  raw UART RX pin, idle high, asynchronous to clk
data_out  output  NUM_BYTES*8  last good payload; byte 0 in [7:0] (little-endian)
valid_out  output  1  one-cycle pulse: data_out just updated with a good packet
crc_err_out  output  1  one-cycle pulse: checksum mismatch
frame_err_out  output  1  one-cycle pulse: bad stop bit or inter-byte timeout
busy_out  output  1  high while a byte or packet is in progress

Behaviour:
- Reset (async, rst_n_in=0):
  - Synchronizer flops go to 1; all counters go to 0; FSM goes to HUNT.
  - data_out=0; valid_out, crc_err_out, frame_err_out go to 0.
  - Reset mid-packet discards the partial packet with no error pulse.
- Input: line_in passes through a 2-flop synchronizer; all logic uses the synchronized bit rx_s.
- Byte receiver, states IDLE, START, DATA, STOP:
  - IDLE->START when rx_s=0; bit counter and cycle counter clear.
  - START: at cycle DIVISOR/2, if rx_s=1, treat as a glitch and return to IDLE with no output; otherwise clear the cycle counter and go to DATA.
  - DATA: sample rx_s every DIVISOR cycles, mid-bit, LSB first, 8 bits.
  - STOP: sample DIVISOR cycles after bit 7.
    - rx_s=1: pulse byte_valid with the byte.
    - rx_s=0: pulse byte_ferr and discard the byte.
    - Either way return to IDLE in the same cycle (mid-stop-bit), so back-to-back bytes are accepted.
- Packet FSM, states HUNT, PAYLOAD, CHECK:
  - HUNT: a byte equal to SYNC_BYTE goes to PAYLOAD with index=0 and running XOR=0. Other bytes are ignored silently. byte_ferr in HUNT is ignored, with no pulse.
  - PAYLOAD: each byte goes into a shadow register at lane index, is XORed into the checksum, and index increments. After byte NUM_BYTES-1, go to CHECK. SYNC_BYTE values here are plain data.
  - CHECK, byte equals running XOR: data_out <= shadow and valid_out=1 on the cycle after byte_valid; go to HUNT.
  - CHECK, byte differs: crc_err_out pulses for one cycle at the same latency; data_out unchanged; go to HUNT.
  - byte_ferr in PAYLOAD or CHECK: frame_err_out pulses on the next cycle; go to HUNT.
  - Timeout: in PAYLOAD or CHECK, a counter clears on every byte_valid. When it reaches TIMEOUT_BITS*DIVISOR with the byte receiver in IDLE, frame_err_out pulses and the FSM goes to HUNT.
  - Counter width: $clog2(TIMEOUT_BITS*DIVISOR+1).
- Simultaneous events: at most one of valid_out, crc_err_out, frame_err_out is high in any cycle. A timeout and a start bit in the same cycle resolve to the timeout.
- busy_out = (packet FSM != HUNT) | (byte receiver != IDLE).
- Latency: the last stop-bit sample to valid_out is exactly 1 clk.

Decomposition:
- Package serial_pkg holds:
  - the byte-receiver and packet-state enums;
  - the default SYNC_BYTE and DIVISOR constants, shared with the matching serial_packet_tx.
- One sub-module, serial_rx_core: synchronizer plus byte receiver, with outputs byte, byte_valid, byte_ferr and idle.
- The packet FSM and timeout live in serial_packet_rx.

Test Plan:
All scenarios use DIVISOR=16, NUM_BYTES=4, TIMEOUT_BITS=20, 8N1 bit periods of 16 clk.
- Good packet: send A5 11 22 33 44 then checksum 44 -> exactly one valid_out, 1 clk after the last stop-bit sample; data_out=32'h44332211; no error pulses.
- Bad checksum: send A5 11 22 33 44 45 -> one crc_err_out pulse; no valid_out; data_out keeps its previous value; then send a good packet AA BB CC DD with checksum 00 -> data_out=32'hDDCCBBAA.
- Noise before sync: send 00 FF 5A, then a good packet with payload A5 A5 A5 A5 and checksum 00 -> exactly one valid_out; data_out=32'hA5A5A5A5.
- Glitch and framing error:
  - drive a 4-clk low pulse on an idle line -> no byte accepted; busy_out returns low.
  - send A5 01 with stop bit forced 0 -> frame_err_out pulse; the following good packet is accepted.
- Timeout: send A5 01 02, then leave the line idle -> frame_err_out 320 clk after the last byte_valid; FSM in HUNT; busy_out=0.
- Reset mid-packet: assert rst_n_in during payload byte 2 for 3 clk -> all outputs 0 immediately (asynchronous); after release, a fresh good packet produces valid_out.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and defaults for the framed UART packet link.
// The tx end reuses the sync byte and bit-period constants.
package serial_pkg;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {PktHunt, PktPayload, PktCheck} pkt_state_e;

    localparam int unsigned DefaultDivisor  = 868;
    localparam logic [7:0]  DefaultSyncByte = 8'hA5;

endpackage

// File: rtl/serial_rx_core.sv
// 8N1 byte receiver: two-flop input synchronizer, mid-bit sampling, stop-bit check.
module serial_rx_core
    import serial_pkg::*;
#(
    parameter int unsigned DIVISOR = DefaultDivisor
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_ferr,
    output logic       idle
);

    localparam int unsigned     CntW    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CntW-1:0] HalfCnt = CntW'(DIVISOR / 2);
    localparam logic [CntW-1:0] LastCnt = CntW'(DIVISOR - 1);

    logic            sync1_q;
    logic            rx_s;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
            state_q <= RxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= line;
            rx_s    <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            RxIdle: begin
                if (!rx_s) begin
                    state_d = RxStart;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            RxStart: begin
                if (cnt_q == HalfCnt) begin
                    // Line back high at mid start bit: glitch, not a byte.
                    if (rx_s) begin
                        state_d = RxIdle;
                    end else begin
                        state_d = RxData;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RxData: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RxStop;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RxStop: begin
                if (cnt_q == LastCnt) begin
                    state_d = RxIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    always_comb begin
        rx_byte    = shift_q;
        byte_valid = (state_q == RxStop) && (cnt_q == LastCnt) && rx_s;
        byte_ferr  = (state_q == RxStop) && (cnt_q == LastCnt) && !rx_s;
        idle       = (state_q == RxIdle);
    end

endmodule

// File: rtl/serial_packet_rx.sv
// Packet layer: hunts for the sync byte, gathers the payload, checks the XOR
// checksum and guards the inter-byte gap with a timeout.
module serial_packet_rx
    import serial_pkg::*;
#(
    parameter int unsigned DIVISOR      = DefaultDivisor,
    parameter int unsigned NUM_BYTES    = 4,
    parameter logic [7:0]  SYNC_BYTE    = DefaultSyncByte,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                   clk,
    input  logic                   rst_n_in,
    input  logic                   line_in,
    output logic [NUM_BYTES*8-1:0] data_out,
    output logic                   valid_out,
    output logic                   crc_err_out,
    output logic                   frame_err_out,
    output logic                   busy_out
);

    localparam int unsigned ToLimit = TIMEOUT_BITS * DIVISOR;
    localparam int unsigned ToW     = $clog2(ToLimit + 1);
    localparam int unsigned W       = NUM_BYTES * 8;
    localparam logic [2:0]  LastIdx = 3'(NUM_BYTES - 1);

    logic [7:0]     rx_byte;
    logic           byte_valid;
    logic           byte_ferr;
    logic           idle;
    logic           timeout_hit;

    pkt_state_e     state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     xor_q, xor_d;
    logic [W-1:0]   shadow_q, shadow_d;
    logic [W-1:0]   data_q, data_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           valid_q, valid_d;
    logic           crc_q, crc_d;
    logic           ferr_q, ferr_d;

    serial_rx_core #(
        .DIVISOR (DIVISOR)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n_in),
        .line       (line_in),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .byte_ferr  (byte_ferr),
        .idle       (idle)
    );

    // Only fires with the receiver idle, so it never coincides with a byte event.
    assign timeout_hit = (state_q != PktHunt) && (to_cnt_q >= ToW'(ToLimit - 1)) && idle;

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= PktHunt;
            idx_q    <= '0;
            xor_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            to_cnt_q <= '0;
            valid_q  <= 1'b0;
            crc_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            xor_q    <= xor_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            to_cnt_q <= to_cnt_d;
            valid_q  <= valid_d;
            crc_q    <= crc_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        xor_d    = xor_q;
        shadow_d = shadow_q;
        to_cnt_d = to_cnt_q;
        if (state_q == PktHunt || byte_valid) begin
            to_cnt_d = '0;
        end else if (to_cnt_q < ToW'(ToLimit)) begin
            to_cnt_d = to_cnt_q + ToW'(1);
        end
        case (state_q)
            PktHunt: begin
                if (byte_valid && rx_byte == SYNC_BYTE) begin
                    state_d = PktPayload;
                    idx_d   = '0;
                    xor_d   = '0;
                end
            end
            PktPayload: begin
                if (timeout_hit || byte_ferr) begin
                    state_d = PktHunt;
                end else if (byte_valid) begin
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (idx_q == 3'(i)) shadow_d[i*8 +: 8] = rx_byte;
                    end
                    xor_d = xor_q ^ rx_byte;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == LastIdx) state_d = PktCheck;
                end
            end
            PktCheck: begin
                if (timeout_hit || byte_ferr || byte_valid) state_d = PktHunt;
            end
            default: state_d = PktHunt;
        endcase
    end

    always_comb begin
        valid_d  = (state_q == PktCheck) && byte_valid && (rx_byte == xor_q);
        crc_d    = (state_q == PktCheck) && byte_valid && (rx_byte != xor_q);
        ferr_d   = (state_q != PktHunt) && (byte_ferr || timeout_hit);
        data_d   = valid_d ? shadow_q : data_q;
        busy_out = (state_q != PktHunt) || !idle;
    end

    assign data_out      = data_q;
    assign valid_out     = valid_q;
    assign crc_err_out   = crc_q;
    assign frame_err_out = ferr_q;

endmodule
